// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the comparator arbiter slice.
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RSP  = 2'd2
  } cmpArbState_e;

  localparam int CMP_GT = 0;
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 2;

endpackage

// File: rtl/Comparator.sv
// Shared unsigned magnitude comparator; exactly one of gt/eq/lt is high.
module Comparator #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oGt,
  output logic             oEq,
  output logic             oLt
);

  assign oGt = (iA > iB);
  assign oEq = (iA == iB);
  assign oLt = (iA < iB);

endmodule

// File: rtl/compare_rr_pick.sv
// Rotating-priority picker: first set request at or after iPtr, with wrap-around.
module compare_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] iReq,
  input  logic [IW-1:0]      iPtr,
  output logic [NUM_REQ-1:0] oGnt,
  output logic [IW-1:0]      oIdx,
  output logic               oAny
);

  logic [IW-1:0] jIdx_s;
  logic          found_s;

  // Scan from the pointer upward and keep the first hit.
  always_comb begin
    oGnt    = '0;
    oIdx    = '0;
    jIdx_s  = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      jIdx_s = IW'((int'(iPtr) + k) % NUM_REQ);
      if (!found_s && iReq[jIdx_s]) begin
        found_s      = 1'b1;
        oIdx         = jIdx_s;
        oGnt[jIdx_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    oAny = found_s;
  end

endmodule

// File: rtl/compare_arbiter.sv
// Shares one Comparator among NUM_REQ requesters with an IDLE/CMP/RSP sequence.
// Define CMP_ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed lowest-index priority.
module compare_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                       iClk,
  input  logic                       iRstN,
  input  logic [NUM_REQ-1:0]         iReq,
  input  logic [NUM_REQ*WIDTH-1:0]   iDataA,
  input  logic [NUM_REQ*WIDTH-1:0]   iDataB,
  output logic [NUM_REQ-1:0]         oGnt,
  output logic [NUM_REQ-1:0]         oValid,
  output logic [2:0]                 oResult,
  output logic                       oBusy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  cmpArbState_e        state_r, nextState_s;
  logic [NUM_REQ-1:0]  gnt_r, valid_r;
  logic [2:0]          result_r, cmpRes_s;
  logic                busy_r;
  logic [WIDTH-1:0]    opA_r, opB_r;
  logic [NUM_REQ-1:0]  pickGnt_s;
  logic [IW-1:0]       pickIdx_s, ptr_s;
  logic                pickAny_s;
  logic                gt_s, eq_s, lt_s;

`ifdef CMP_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_r;

  // Pointer moves just past the most recent winner.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      ptr_r <= '0;
    end else if (state_r == IDLE && pickAny_s) begin
      ptr_r <= (pickIdx_s == IW'(NUM_REQ - 1)) ? '0 : pickIdx_s + IW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
  assign ptr_s = ptr_r;
`else
  assign ptr_s = '0;
`endif

  compare_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) uPick (
    .iReq (iReq),
    .iPtr (ptr_s),
    .oGnt (pickGnt_s),
    .oIdx (pickIdx_s),
    .oAny (pickAny_s)
  );

  Comparator #(.WIDTH(WIDTH)) uCmp (
    .iA  (opA_r),
    .iB  (opB_r),
    .oGt (gt_s),
    .oEq (eq_s),
    .oLt (lt_s)
  );

  // Pack comparator flags into the result encoding.
  always_comb begin
    cmpRes_s         = 3'b000;
    cmpRes_s[CMP_GT] = gt_s;
    cmpRes_s[CMP_EQ] = eq_s;
    cmpRes_s[CMP_LT] = lt_s;
  end

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state logic; requests only matter in IDLE.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE:    nextState_s = pickAny_s ? CMP : IDLE;
      CMP:     nextState_s = RSP;
      RSP:     nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Grant/operand capture, result registration and strobe/grant release.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      gnt_r    <= '0;
      valid_r  <= '0;
      result_r <= 3'b000;
      busy_r   <= 1'b0;
      opA_r    <= '0;
      opB_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pickAny_s) begin
            gnt_r  <= pickGnt_s;
            busy_r <= 1'b1;
            opA_r  <= iDataA[int'(pickIdx_s)*WIDTH +: WIDTH];
            opB_r  <= iDataB[int'(pickIdx_s)*WIDTH +: WIDTH];
          end else begin
            busy_r <= 1'b0;
          end
        end
        CMP: begin
          result_r <= cmpRes_s;
          valid_r  <= gnt_r;
        end
        RSP: begin
          valid_r <= '0;
          gnt_r   <= '0;
          busy_r  <= 1'b0;
        end
        default: begin
          valid_r <= '0;
          gnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign oGnt    = gnt_r;
  assign oValid  = valid_r;
  assign oResult = result_r;
  assign oBusy   = busy_r;

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed self-checking bench for compare_arbiter (NUM_REQ=4, WIDTH=32).
module tb_compare_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           iClk;
  logic           iRstN;
  logic [N-1:0]   iReq;
  logic [N*W-1:0] iDataA;
  logic [N*W-1:0] iDataB;
  logic [N-1:0]   oGnt;
  logic [N-1:0]   oValid;
  logic [2:0]     oResult;
  logic           oBusy;

  int nChecks = 0;
  int nFails  = 0;

  compare_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iReq    (iReq),
    .iDataA  (iDataA),
    .iDataB  (iDataB),
    .oGnt    (oGnt),
    .oValid  (oValid),
    .oResult (oResult),
    .oBusy   (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic setOps(input int idx, input logic [31:0] a, input logic [31:0] b);
    iDataA[idx*W +: W] = a;
    iDataB[idx*W +: W] = b;
  endtask

  // Single isolated transaction from IDLE, checking the full n+1..n+3 timeline.
  task automatic doTxn(input string tag, input int idx, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] expRes);
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    setOps(idx, a, b);
    iReq = oh;
    step();
    checkVal({tag, "_gnt"}, 32'(oGnt), 32'(oh));
    checkVal({tag, "_busy1"}, 32'(oBusy), 32'd1);
    checkVal({tag, "_noval"}, 32'(oValid), 32'd0);
    iReq = '0;
    step();
    checkVal({tag, "_valid"}, 32'(oValid), 32'(oh));
    checkVal({tag, "_res"}, 32'(oResult), 32'(expRes));
    step();
    checkVal({tag, "_busy0"}, 32'(oBusy), 32'd0);
    checkVal({tag, "_valclr"}, 32'(oValid), 32'd0);
    checkVal({tag, "_hold"}, 32'(oResult), 32'(expRes));
  endtask

  initial begin
    logic [N-1:0] expG;
    iRstN  = 1'b0;
    iReq   = '0;
    iDataA = '0;
    iDataB = '0;
    step();
    step();
    checkVal("rst_gnt", 32'(oGnt), 32'd0);
    checkVal("rst_valid", 32'(oValid), 32'd0);
    checkVal("rst_res", 32'(oResult), 32'd0);
    checkVal("rst_busy", 32'(oBusy), 32'd0);
    iRstN = 1'b1;
    step();

    doTxn("gt", 0, 32'd5, 32'd3, 3'b001);
    doTxn("eq", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010);
    doTxn("lt", 2, 32'h0000_0000, 32'hFFFF_FFFF, 3'b100);

    // All requesters active, starting from a fresh pointer.
    iRstN = 1'b0;
    #1;
    iRstN = 1'b1;
    for (int i = 0; i < N; i++) setOps(i, 32'(i), 32'd1);
    iReq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      expG = '0;
`ifdef CMP_ARB_ROUND_ROBIN_EN
      expG[k % N] = 1'b1;
`else
      expG[0] = 1'b1;
`endif
      checkVal($sformatf("all_gnt%0d", k), 32'(oGnt), 32'(expG));
      if (k == 4) iReq = '0;
      step();
      checkVal($sformatf("all_val%0d", k), 32'(oValid), 32'(expG));
      step();
    end

    // Requester 1 drops during CMP while requester 3 arrives.
    setOps(1, 32'd1, 32'd2);
    setOps(3, 32'd7, 32'd7);
    iReq = 4'b0010;
    step();
    checkVal("drop_gnt1", 32'(oGnt), 32'b0010);
    iReq = 4'b1000;
    step();
    checkVal("drop_val1", 32'(oValid), 32'b0010);
    checkVal("drop_res1", 32'(oResult), 32'b100);
    step();
    checkVal("drop_idle", 32'(oGnt), 32'd0);
    step();
    checkVal("drop_gnt3", 32'(oGnt), 32'b1000);
    iReq = '0;
    step();
    checkVal("drop_val3", 32'(oValid), 32'b1000);
    checkVal("drop_res3", 32'(oResult), 32'b010);
    step();

    // Reset asserted during CMP drops the transaction at once.
    setOps(0, 32'd9, 32'd1);
    iReq = 4'b0001;
    step();
    checkVal("mrst_gnt", 32'(oGnt), 32'b0001);
    iRstN = 1'b0;
    iReq  = '0;
    #1;
    checkVal("mrst_gnt0", 32'(oGnt), 32'd0);
    checkVal("mrst_busy0", 32'(oBusy), 32'd0);
    checkVal("mrst_res0", 32'(oResult), 32'd0);
    step();
    checkVal("mrst_noval", 32'(oValid), 32'd0);
    iRstN = 1'b1;
    step();
    checkVal("mrst_noval2", 32'(oValid), 32'd0);

    // Unsigned boundary via requester 3 after reset release.
    doTxn("ubnd", 3, 32'h8000_0000, 32'h7FFF_FFFF, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
